da_seq_accum: RTL

//   Parametrised time-multiplexed select-and-accumulate engine. Latches N_CH

---
 rtl/da_seq_accum.sv | 139 +++++++++++++
 1 files changed

// File: rtl/da_seq_accum.sv
// Time-multiplexed select-and-accumulate engine: sums the selected coefficients of a
// latched frame LANES channels per cycle into a wrapping accumulator.
module da_seq_accum #(
    parameter int N_CH   = 16,
    parameter int LANES  = 4,
    parameter int TW     = 28,
    parameter int ACC_W  = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_CH-1:0]      x_bits,
    input  logic [N_CH*TW-1:0]   t_vec,
    input  logic                 acc_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     y,
    output logic                 busy
);

    localparam int PHASES = N_CH / LANES;
    localparam int PH_W   = (PHASES > 1) ? $clog2(PHASES) : 1;
    localparam int CW     = (N_CH > 1) ? $clog2(N_CH) : 1;

    if (N_CH % LANES != 0) begin : g_lanes_chk
        $error("da_seq_accum: N_CH must be a multiple of LANES");
    end
    if (ACC_W < TW + $clog2(N_CH)) begin : g_width_chk
        $error("da_seq_accum: ACC_W too narrow for N_CH coefficients of width TW");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  y_q, y_d;
    logic              out_valid_q, out_valid_d;
    logic              cap_en;
    logic [ACC_W-1:0]  part;

    logic [N_CH-1:0]   xb_q;
    logic [TW-1:0]     t_q [N_CH];

    function automatic logic [ACC_W-1:0] ext(input logic [TW-1:0] w);
        if (SIGNED) return ACC_W'($signed(w));
        else        return ACC_W'(w);
    endfunction

    // NOTE: operand registers carry no reset; they are always written at frame
    // acceptance before anything reads them, so a reset would only add fan-out.
    always_ff @(posedge clk) begin
        if (cap_en) begin
            xb_q <= x_bits;
            for (int i = 0; i < N_CH; i++) begin
                t_q[i] <= t_vec[i*TW +: TW];
            end
        end
    end

    // Lane l of the current phase looks at channel phase*LANES + l.
    always_comb begin : p_part
        logic [CW-1:0] ch;
        part = '0;
        ch   = '0;
        for (int l = 0; l < LANES; l++) begin
            ch = CW'(int'(phase_q) * LANES + l);
            if (xb_q[ch]) part = part + ext(t_q[ch]);
        end
    end

    // NOTE: every variable gets its default before the case so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        acc_d       = acc_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;
        cap_en      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    cap_en  = 1'b1;
                    phase_d = '0;
                    if (!acc_mode) acc_d = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d   = acc_q + part;
                phase_d = phase_q + PH_W'(1);
                if (phase_q == PH_W'(PHASES - 1)) begin
                    y_d         = acc_q + part;
                    out_valid_d = 1'b1;
                    phase_d     = '0;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            acc_q       <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            acc_q       <= acc_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_RUN);
    assign out_valid = out_valid_q;
    assign y         = y_q;

endmodule
